// File: rtl/parking_button_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parking_pkg
// Description : Shared constants for the parking button conditioner: button
//               indices, the arbiter priority order and the grant helper.
// Revision    : 1.0 - initial release
// ============================================================================
package parking_pkg;

    localparam int NUM_BTN  = 6;

    // Bit positions of each button inside every button-wide vector
    localparam int BTN_ADD1 = 0;
    localparam int BTN_ADD2 = 1;
    localparam int BTN_ADD3 = 2;
    localparam int BTN_ADD4 = 3;
    localparam int BTN_RST1 = 4;
    localparam int BTN_RST2 = 5;

    typedef logic [NUM_BTN-1:0] btn_vec_t;

    // Buttons allowed to auto-repeat: the four add tiers only
    localparam btn_vec_t REPEAT_MASK = 6'b00_1111;

    // Arbiter order, highest priority first
    localparam int PRIO_ORDER [NUM_BTN] = '{BTN_RST2, BTN_RST1, BTN_ADD4,
                                            BTN_ADD3, BTN_ADD2, BTN_ADD1};

    // One-hot grant of the highest-priority requesting button
    function automatic btn_vec_t pick_grant(input btn_vec_t req);
        logic found;
        pick_grant = '0;
        found      = 1'b0;
        for (int k = 0; k < NUM_BTN; k++) begin
            if (!found && req[PRIO_ORDER[k]]) begin
                pick_grant[PRIO_ORDER[k]] = 1'b1;
                found                     = 1'b1;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/parking_button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : parking_button_conditioner_if
// Description : Raw board buttons in, one-cycle meter event pulses out.
// Revision    : 1.0 - initial release
// ============================================================================
interface parking_button_conditioner_if;

    logic btn_add1;
    logic btn_add2;
    logic btn_add3;
    logic btn_add4;
    logic btn_rst1;
    logic btn_rst2;

    logic add1;
    logic add2;
    logic add3;
    logic add4;
    logic rst1;
    logic rst2;

    // Board / stimulus side: drives raw buttons, observes events
    modport master (
        output btn_add1, btn_add2, btn_add3, btn_add4, btn_rst1, btn_rst2,
        input  add1, add2, add3, add4, rst1, rst2
    );

    // Conditioner side
    modport slave (
        input  btn_add1, btn_add2, btn_add3, btn_add4, btn_rst1, btn_rst2,
        output add1, add2, add3, add4, rst1, rst2
    );

endinterface
`default_nettype wire

// File: rtl/parking_button_conditioner_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : 2-flop synchroniser, stable-count debouncer and registered
//               rising-edge pulse for one raw button. The debounced level is
//               exported only when PARKING_AUTOREPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int DB_CYCLES = 3
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_raw,
    output logic o_rise
`ifdef PARKING_AUTOREPEAT_EN
    ,
    output logic o_level
`endif
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          level_q, level_d;
    logic          rise_q,  rise_d;

    // Level flips once the synced input has disagreed for DB_CYCLES cycles
    always_comb begin
        sync1_d = i_raw;
        sync2_d = sync1_q;
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers, all cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign o_rise = rise_q;
`ifdef PARKING_AUTOREPEAT_EN
    assign o_level = level_q;
`endif

endmodule
`default_nettype wire

// File: rtl/parking_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : parking_button_conditioner
// Description : Debounces six meter buttons, queues each press in a pending
//               bit and issues at most one single-cycle event per clock via a
//               fixed-priority arbiter (rst2 > rst1 > add4 > ... > add1).
//               Optional macro PARKING_AUTOREPEAT_EN adds hold-to-repeat on
//               the add buttons.
// Revision    : 1.0 - initial release
// ============================================================================
module parking_button_conditioner
    import parking_pkg::*;
#(
    parameter int DB_CYCLES     = 3,
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_PERIOD = 10
) (
    input  wire clk,
    input  wire rst,
    parking_button_conditioner_if.slave bus
);

    btn_vec_t btn_raw;
    btn_vec_t rise;
    btn_vec_t rep_set;
    btn_vec_t grant;
    btn_vec_t pending_q, pending_d;
    btn_vec_t out_q,     out_d;
`ifdef PARKING_AUTOREPEAT_EN
    btn_vec_t level;
`endif

    assign btn_raw[BTN_ADD1] = bus.btn_add1;
    assign btn_raw[BTN_ADD2] = bus.btn_add2;
    assign btn_raw[BTN_ADD3] = bus.btn_add3;
    assign btn_raw[BTN_ADD4] = bus.btn_add4;
    assign btn_raw[BTN_RST1] = bus.btn_rst1;
    assign btn_raw[BTN_RST2] = bus.btn_rst2;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk     (clk),
            .rst     (rst),
            .i_raw   (btn_raw[i]),
            .o_rise  (rise[i])
`ifdef PARKING_AUTOREPEAT_EN
            ,
            .o_level (level[i])
`endif
        );
    end

`ifdef PARKING_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW      = $clog2(REP_MAX + 1);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_repeat
        logic [TW-1:0] tmr_q, tmr_d;
        logic          started_q, started_d;
        logic          rep_fire;

        // Count down from each grant; expiry re-arms the pending bit
        always_comb begin
            tmr_d     = tmr_q;
            started_d = started_q;
            rep_fire  = 1'b0;
            if (!level[i] || !REPEAT_MASK[i]) begin
                tmr_d     = '0;
                started_d = 1'b0;
            end else if (grant[i]) begin
                tmr_d     = started_q ? TW'(REPEAT_PERIOD - 1) : TW'(REPEAT_DELAY - 1);
                started_d = 1'b1;
            end else if (tmr_q != '0) begin
                tmr_d    = tmr_q - TW'(1);
                rep_fire = (tmr_q == TW'(1));
            end
        end

        // Repeat timer state
        always_ff @(posedge clk) begin
            if (rst) begin
                tmr_q     <= '0;
                started_q <= 1'b0;
            end else begin
                tmr_q     <= tmr_d;
                started_q <= started_d;
            end
        end

        assign rep_set[i] = rep_fire;
    end
`else
    assign rep_set = '0;
`endif

    // Grant one pending press per cycle, never the button already pulsing
    always_comb begin
        grant     = pick_grant(pending_q & ~out_q);
        out_d     = grant;
        pending_d = (pending_q & ~grant) | rise | rep_set;
    end

    // Pending vector and registered event outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            out_q     <= '0;
        end else begin
            pending_q <= pending_d;
            out_q     <= out_d;
        end
    end

    assign bus.add1 = out_q[BTN_ADD1];
    assign bus.add2 = out_q[BTN_ADD2];
    assign bus.add3 = out_q[BTN_ADD3];
    assign bus.add4 = out_q[BTN_ADD4];
    assign bus.rst1 = out_q[BTN_RST1];
    assign bus.rst2 = out_q[BTN_RST2];

endmodule
`default_nettype wire

// File: tb/tb_parking_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_parking_button_conditioner
// Description : Self-checking bench for parking_button_conditioner: vector
//               table, corner-case sequences and a randomized run compared
//               against a sliding-window reference model. Honours
//               PARKING_AUTOREPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_button_conditioner;

    localparam int DB = 3;
    localparam int RD = 50;
    localparam int RP = 10;

    // Vector bit order: {rst2, rst1, add4, add3, add2, add1}
    typedef struct packed {
        logic [5:0]      btn;
        logic [4:0]      hold;
        logic [5:0][5:0] seq;   // expected outputs at cycles 6..11
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    parking_button_conditioner_if bus();

    parking_button_conditioner #(
        .DB_CYCLES     (DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [5:0] btn_v    = '0;
    logic [5:0] out_v;

    // Reference model state
    bit [7:0] m_hist [6];
    bit [5:0] m_lvl, m_rise, m_pend, m_out;
    bit       m_started [4];
    int       m_next [4];
    int       m_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One clock edge of the specified behaviour
    task automatic model_step();
        bit [5:0] grant, npend, nrise, nlvl;
        bit       flip;
        m_cyc++;
        if (rst) begin
            for (int b = 0; b < 6; b++) m_hist[b] = '0;
            for (int b = 0; b < 4; b++) begin m_started[b] = 0; m_next[b] = -1; end
            m_lvl = '0; m_rise = '0; m_pend = '0; m_out = '0;
            return;
        end
        grant = '0;
        for (int b = 5; b >= 0; b--)
            if (m_pend[b] && !m_out[b] && grant == 0) grant[b] = 1'b1;
        npend = (m_pend & ~grant) | m_rise;
`ifdef PARKING_AUTOREPEAT_EN
        for (int b = 0; b < 4; b++) begin
            if (!m_lvl[b]) begin
                m_started[b] = 0; m_next[b] = -1;
            end else if (grant[b]) begin
                m_next[b] = m_cyc + (m_started[b] ? RP : RD) - 1;
                m_started[b] = 1;
            end else if (m_cyc == m_next[b]) begin
                npend[b] = 1'b1; m_next[b] = -1;
            end
        end
`endif
        nrise = '0;
        nlvl  = m_lvl;
        for (int b = 0; b < 6; b++) begin
            m_hist[b] = {m_hist[b][6:0], btn_v[b]};
            flip = 1;
            for (int k = 2; k <= DB + 1; k++)
                if (m_hist[b][k] == m_lvl[b]) flip = 0;
            if (flip) begin
                nlvl[b]  = ~m_lvl[b];
                nrise[b] = ~m_lvl[b];
            end
        end
        m_out = grant; m_pend = npend; m_rise = nrise; m_lvl = nlvl;
    endtask

    task automatic drive(input logic [5:0] v, input logic r);
        btn_v = v;
        rst   = r;
        bus.btn_add1 = v[0];
        bus.btn_add2 = v[1];
        bus.btn_add3 = v[2];
        bus.btn_add4 = v[3];
        bus.btn_rst1 = v[4];
        bus.btn_rst2 = v[5];
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        out_v = {bus.rst2, bus.rst1, bus.add4, bus.add3, bus.add2, bus.add1};
    endtask

    function automatic vec_t mk(input logic [5:0] b, input int h,
                                input logic [5:0] s0, input logic [5:0] s1, input logic [5:0] s2,
                                input logic [5:0] s3, input logic [5:0] s4, input logic [5:0] s5);
        vec_t v;
        v.btn = b; v.hold = 5'(h);
        v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2;
        v.seq[3] = s3; v.seq[4] = s4; v.seq[5] = s5;
        return v;
    endfunction

    vec_t vecs [12];

    initial begin
        int         cnt, other, first;
        int         exp_q[$];
        int         got_q[$];
        logic [5:0] e, v;

        vecs[0]  = mk(6'b000001, 20, 6'b000001, 0, 0, 0, 0, 0);
        vecs[1]  = mk(6'b000010, 20, 6'b000010, 0, 0, 0, 0, 0);
        vecs[2]  = mk(6'b000100, 20, 6'b000100, 0, 0, 0, 0, 0);
        vecs[3]  = mk(6'b001000, 20, 6'b001000, 0, 0, 0, 0, 0);
        vecs[4]  = mk(6'b010000, 20, 6'b010000, 0, 0, 0, 0, 0);
        vecs[5]  = mk(6'b100000, 20, 6'b100000, 0, 0, 0, 0, 0);
        vecs[6]  = mk(6'b100001, 20, 6'b100000, 6'b000001, 0, 0, 0, 0);
        vecs[7]  = mk(6'b111111, 20, 6'b100000, 6'b010000, 6'b001000,
                                     6'b000100, 6'b000010, 6'b000001);
        vecs[8]  = mk(6'b000010,  2, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(6'b000010,  3, 6'b000010, 0, 0, 0, 0, 0);
        vecs[10] = mk(6'b000110, 10, 6'b000100, 6'b000010, 0, 0, 0, 0);
        vecs[11] = mk(6'b011001, 10, 6'b010000, 6'b001000, 6'b000001, 0, 0, 0);

        drive('0, 1'b1);
        tick(); tick();
        check("reset_state", int'(out_v), 0);
        drive('0, 1'b0);
        for (int c = 0; c < 5; c++) tick();
        check("idle_after_reset", int'(out_v), 0);

        // Table vectors: one press pattern each, outputs checked every cycle
        for (int i = 0; i < 12; i++) begin
            for (int c = 0; c < 32; c++) begin
                drive((c < int'(vecs[i].hold)) ? vecs[i].btn : 6'b0, 1'b0);
                tick();
                e = (c >= 6 && c < 12) ? vecs[i].seq[c-6] : 6'b0;
                check($sformatf("vec%0d_cycle%0d", i, c), int'(out_v), int'(e));
            end
        end

        // add3 toggling then held: single pulse
        cnt = 0; other = 0;
        for (int c = 0; c < 36; c++) begin
            drive((c < 6) ? ((c % 2 == 0) ? 6'b000100 : 6'b0) : ((c < 16) ? 6'b000100 : 6'b0), 1'b0);
            tick();
            cnt   += int'(out_v[2]);
            other += int'($countones(out_v & ~6'b000100));
        end
        check("toggle_add3_pulses", cnt, 1);
        check("toggle_other_pulses", other, 0);

        // add4 short press killed by reset
        drive(6'b001000, 1'b0); tick(); tick();
        drive(6'b0, 1'b1); tick();
        check("out_after_rst", int'(out_v), 0);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin drive(6'b0, 1'b0); tick(); cnt += $countones(out_v); end
        check("short_press_rst_pulses", cnt, 0);

        // add4 debounced and pending when reset hits: event discarded
        for (int c = 0; c < 5; c++) begin drive(6'b001000, 1'b0); tick(); end
        drive(6'b0, 1'b1); tick();
        cnt = 0;
        for (int c = 0; c < 20; c++) begin drive(6'b0, 1'b0); tick(); cnt += $countones(out_v); end
        check("pending_rst_pulses", cnt, 0);

        // add1 held across reset: one pulse at normal latency after deassert
        for (int c = 0; c < 10; c++) begin drive(6'b000001, 1'b0); tick(); end
        drive(6'b000001, 1'b1); tick();
        check("held_rst_out", int'(out_v), 0);
        cnt = 0; first = -1;
        for (int c = 0; c < 20; c++) begin
            drive(6'b000001, 1'b0); tick();
            if (out_v != 0) begin cnt++; if (first < 0) first = c; end
        end
        check("held_rst_first_pulse", first, 6);
        check("held_rst_pulses", cnt, 1);
        for (int c = 0; c < 15; c++) begin drive(6'b0, 1'b0); tick(); end

        // add4 held 200 cycles
        exp_q.push_back(6);
`ifdef PARKING_AUTOREPEAT_EN
        for (int t = 56; t <= 196; t += 10) exp_q.push_back(t);
`endif
        other = 0;
        for (int c = 0; c < 230; c++) begin
            drive((c < 200) ? 6'b001000 : 6'b0, 1'b0); tick();
            if (out_v[3]) got_q.push_back(c);
            other += $countones(out_v & ~6'b001000);
        end
        check("hold_add4_count", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check($sformatf("hold_add4_pulse%0d", k), got_q[k], exp_q[k]);
        check("hold_add4_other", other, 0);

        // rst1 held 200 cycles: never repeats
        cnt = 0; other = 0;
        for (int c = 0; c < 230; c++) begin
            drive((c < 200) ? 6'b010000 : 6'b0, 1'b0); tick();
            cnt   += int'(out_v[4]);
            other += $countones(out_v & ~6'b010000);
        end
        check("hold_rst1_pulses", cnt, 1);
        check("hold_rst1_other", other, 0);

        // Randomized run against the reference model
        v = '0;
        for (int c = 0; c < 3000; c++) begin
            int div;
            div = ((c / 300) % 2 == 0) ? 4 : 60;
            for (int b = 0; b < 6; b++)
                if ($urandom_range(0, div - 1) == 0) v[b] = ~v[b];
            drive(v, ($urandom_range(0, 499) == 0));
            tick();
            check("random_out", int'(out_v), int'(m_out));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
